// File: rtl/arb_muxn.sv
// N-to-1 round-robin arbitrating multiplexer with packet lock and a registered output stage.
// The output carries the source channel index so responses can be routed back.
module arb_muxn #(
    parameter int unsigned dwidth = 1,
    parameter int unsigned swidth = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [(2**swidth)*dwidth-1:0] ins,
    input  logic [(2**swidth)-1:0]        in_valid,
    input  logic [(2**swidth)-1:0]        in_last,
    output logic [(2**swidth)-1:0]        in_ready,
    output logic [dwidth-1:0]             d,
    output logic [swidth-1:0]             sel,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int unsigned seln = 2**swidth;

    logic [swidth-1:0] ptr_q, ptr_d;
    logic              locked_q, locked_d;
    logic [swidth-1:0] lch_q, lch_d;
    logic [dwidth-1:0] data_q, data_d;
    logic [swidth-1:0] sel_q, sel_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;

    logic [swidth-1:0] gnt;
    logic              gnt_vld;
    logic              space;
    logic              accept;
    logic [dwidth-1:0] gnt_data;
    logic              gnt_last;
    logic [swidth-1:0] idx;

    // Grant: locked channel wins outright, otherwise first valid channel at or after ptr.
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        if (locked_q) begin
            gnt     = lch_q;
            gnt_vld = 1'b1;
        end else begin
            // Descending scan so the smallest offset from ptr is the last one written.
            for (int k = seln - 1; k >= 0; k--) begin
                idx = ptr_q + swidth'(k);
                if (in_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    // Per-channel ready: only the granted channel sees space; never depends on ins/in_last.
    always_comb begin
        space    = !valid_q || out_ready;
        in_ready = '0;
        if (gnt_vld) begin
            in_ready[gnt] = space;
        end
    end

    // Select granted channel's payload.
    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int i = 0; i < seln; i++) begin
            if (gnt == swidth'(i)) begin
                gnt_data = ins[i*dwidth +: dwidth];
                gnt_last = in_last[i];
            end
        end
    end

    // Next state: load on accept, drain when downstream takes the beat without a refill.
    always_comb begin
        accept   = gnt_vld && in_valid[gnt] && space;
        ptr_d    = ptr_q;
        locked_d = locked_q;
        lch_d    = lch_q;
        data_d   = data_q;
        sel_d    = sel_q;
        last_d   = last_q;
        valid_d  = valid_q;
        if (accept) begin
            data_d  = gnt_data;
            sel_d   = gnt;
            last_d  = gnt_last;
            valid_d = 1'b1;
            if (gnt_last) begin
                locked_d = 1'b0;
                ptr_d    = gnt + swidth'(1);
            end else begin
                locked_d = 1'b1;
                lch_d    = gnt;
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            locked_q <= 1'b0;
            lch_q    <= '0;
            data_q   <= '0;
            sel_q    <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
            lch_q    <= lch_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
        end
    end

    assign d         = data_q;
    assign sel       = sel_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_arb_muxn.sv
// Directed self-checking bench for arb_muxn with dwidth=8, swidth=2.
module tb_arb_muxn;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic [7:0]  d;
    logic [1:0]  sel;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    arb_muxn #(
        .dwidth(8),
        .swidth(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ins      (ins),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .d        (d),
        .sel      (sel),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ed, input logic [1:0] es,
                           input logic el, input logic ev);
        chk({tag, ".d"}, {24'h0, d}, {24'h0, ed});
        chk({tag, ".sel"}, {30'h0, sel}, {30'h0, es});
        chk({tag, ".last"}, {31'h0, out_last}, {31'h0, el});
        chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, ev});
    endtask

    initial begin
        rst_n     = 1'b0;
        ins       = $urandom;
        in_valid  = 4'b0000;
        in_last   = 4'($urandom);
        out_ready = 1'($urandom);
        #1;
        chk_out("reset_async", 8'h00, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            ins       = $urandom;
            in_last   = 4'($urandom);
            out_ready = 1'($urandom);
        end
        #1;
        chk_out("reset_hold", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("reset_ready", {28'h0, in_ready}, 32'h0);

        // Round-robin over single-beat packets
        tick();
        rst_n     = 1'b1;
        ins       = 32'hA3A2A1A0;
        in_valid  = 4'b1111;
        in_last   = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("rr_ready0", {28'h0, in_ready}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("rr%0d", i), 8'hA0 + 8'(i % 4), 2'(i % 4), 1'b1, 1'b1);
        end
        chk("rr_ready_after", {28'h0, in_ready}, 32'h2);

        // Packet lock on ch1: 11,12,13
        ins     = 32'hA3A211A0;
        in_last = 4'b1101;
        tick();
        chk_out("lock_b0", 8'h11, 2'd1, 1'b0, 1'b1);
        ins = 32'hA3A212A0;
        #1;
        chk("lock_ready", {28'h0, in_ready}, 32'h2);
        tick();
        chk_out("lock_b1", 8'h12, 2'd1, 1'b0, 1'b1);
        ins     = 32'hA3A213A0;
        in_last = 4'b1111;
        tick();
        chk_out("lock_b2", 8'h13, 2'd1, 1'b1, 1'b1);
        chk("lock_next_ready", {28'h0, in_ready}, 32'h4);
        ins = 32'hA3A2A1A0;
        tick();
        chk_out("lock_next", 8'hA2, 2'd2, 1'b1, 1'b1);

        // Backpressure
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_ready%0d", i), {28'h0, in_ready}, 32'h0);
            tick();
            chk_out($sformatf("bp_hold%0d", i), 8'hA2, 2'd2, 1'b1, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {28'h0, in_ready}, 32'h8);
        tick();
        chk_out("bp_release", 8'hA3, 2'd3, 1'b1, 1'b1);

        // Wrap: ptr=0 now; accept ch2 to move ptr to 3, then only ch0 valid
        in_valid = 4'b0100;
        tick();
        chk_out("wrap_setup", 8'hA2, 2'd2, 1'b1, 1'b1);
        in_valid = 4'b0001;
        #1;
        chk("wrap_ready", {28'h0, in_ready}, 32'h1);
        tick();
        chk_out("wrap_grant", 8'hA0, 2'd0, 1'b1, 1'b1);

        // Stall: ch2 non-last beat, then drops valid while ch3 waits
        in_valid = 4'b0100;
        in_last  = 4'b1011;
        ins      = 32'hA322A1A0;
        tick();
        chk_out("stall_b0", 8'h22, 2'd2, 1'b0, 1'b1);
        in_valid = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall_ready%0d", i), {28'h0, in_ready}, 32'h4);
            tick();
            chk($sformatf("stall_valid%0d", i), {31'h0, out_valid}, 32'h0);
        end
        in_valid = 4'b1100;
        in_last  = 4'b1111;
        ins      = 32'hA323A1A0;
        tick();
        chk_out("stall_resume", 8'h23, 2'd2, 1'b1, 1'b1);
        chk("stall_after_ready", {28'h0, in_ready}, 32'h8);

        // Reset mid-packet: ch1 non-last beat, then reset
        in_valid = 4'b0010;
        in_last  = 4'b1101;
        ins      = 32'hA3A231A0;
        tick();
        chk_out("mid_b0", 8'h31, 2'd1, 1'b0, 1'b1);
        chk("mid_locked", {31'h0, dut.locked_q}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_out("mid_reset", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("mid_reset_locked", {31'h0, dut.locked_q}, 32'h0);
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b1111;
        #1;
        chk("post_reset_ready", {28'h0, in_ready}, 32'h1);
        tick();
        chk_out("post_reset_grant", 8'hA0, 2'd0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
